// File: rtl/thor2022_pkg.sv
// Shared opcode constants, prefix-gather state type and opcode classification helpers.
package thor2022_pkg;

   localparam int IW     = 64;
   localparam int PCW    = 32;
   localparam int MAXPFX = 2;

   typedef logic [IW-1:0] instruction_t;

   // Each EXI opcode has a "+1" twin: bit 0 carries immediate data.
   localparam logic [7:0] EXI8  = 8'h46;
   localparam logic [7:0] EXI24 = 8'h48;
   localparam logic [7:0] EXI40 = 8'h4A;
   localparam logic [7:0] EXI56 = 8'h4C;
   localparam logic [7:0] EXIM  = 8'h50;

   typedef enum logic [1:0] {PG_IDLE, PG_X, PG_M, PG_XM} pfx_state_t;

   // Matches an EXI opcode or its +1 form by ignoring bit 0.
   function automatic logic is_exi(input logic [7:0] op);
      return (op[7:1] == EXI8[7:1])  || (op[7:1] == EXI24[7:1]) ||
             (op[7:1] == EXI40[7:1]) || (op[7:1] == EXI56[7:1]);
   endfunction

   function automatic logic is_exim(input logic [7:0] op);
      return op == EXIM;
   endfunction

endpackage

// File: rtl/thor2022_prefix_gather_bundle_reg.sv
// Valid/ready output register for the decode bundle, with synchronous flush.
module thor2022_bundle_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic         take_i,
   input  logic [W-1:0] d_i,
   output logic         valid_o,
   output logic [W-1:0] q_o
);

   // Flush wins, then a load (which may coincide with a take), then a plain take empties.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         q_o     <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         q_o     <= d_i;
      end else if (take_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/thor2022_prefix_gather.sv
// Absorbs EXI/EXIM prefixes ahead of a base instruction and emits one decode bundle
// per base word; holds off interrupts while a prefix group is partially gathered.
module thor2022_prefix_gather
   import thor2022_pkg::*;
#(
   parameter int IW  = 64,
   parameter int PCW = 32
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           flush_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [IW-1:0]  in_ir_i,
   input  logic [PCW-1:0] in_pc_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [IW-1:0]  out_ir_o,
   output logic [IW-1:0]  out_xir_o,
   output logic           out_xval_o,
   output logic [IW-1:0]  out_mir_o,
   output logic           out_mval_o,
   output logic [PCW-1:0] out_pc_o,
   output logic           int_hold_o,
   output logic           pfx_dup_o
);

   localparam int BW = IW*3 + PCW + 2;

   pfx_state_t     state_q, state_n;
   logic [IW-1:0]  xir_q, xir_n, mir_q, mir_n;
   logic [PCW-1:0] gpc_q, gpc_n;
   logic           acc, load, dup, has_x, has_m, op_exi, op_exim;
   logic [BW-1:0]  bdl_d, bdl_q;

   assign in_ready_o = ~flush_i & (~out_valid_o | out_ready_i);
   assign acc        = in_valid_i & in_ready_o;
   assign op_exi     = is_exi(in_ir_i[7:0]);
   assign op_exim    = is_exim(in_ir_i[7:0]);
   assign has_x      = (state_q == PG_X) || (state_q == PG_XM);
   assign has_m      = (state_q == PG_M) || (state_q == PG_XM);

   // Holding registers are zero whenever their prefix is absent, so they feed the bundle as-is.
   assign bdl_d = {in_ir_i, xir_q, has_x, mir_q, has_m,
                   (state_q != PG_IDLE) ? gpc_q : in_pc_i};

   // Next-state: prefix capture, duplicate detection, base-word bundle load, flush.
   always_comb begin
      state_n = state_q;
      xir_n   = xir_q;
      mir_n   = mir_q;
      gpc_n   = gpc_q;
      dup     = 1'b0;
      load    = 1'b0;
      if (flush_i) begin
         state_n = PG_IDLE;
         xir_n   = '0;
         mir_n   = '0;
      end else if (acc) begin
         if (op_exi) begin
            dup   = has_x;
            xir_n = in_ir_i;
            if (state_q == PG_IDLE) gpc_n = in_pc_i;
            state_n = has_m ? PG_XM : PG_X;
         end else if (op_exim) begin
            dup   = has_m;
            mir_n = in_ir_i;
            if (state_q == PG_IDLE) gpc_n = in_pc_i;
            state_n = has_x ? PG_XM : PG_M;
         end else begin
            load    = 1'b1;
            state_n = PG_IDLE;
            xir_n   = '0;
            mir_n   = '0;
         end
      end
   end

   // State and prefix holding registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PG_IDLE;
         xir_q   <= '0;
         mir_q   <= '0;
         gpc_q   <= '0;
      end else begin
         state_q <= state_n;
         xir_q   <= xir_n;
         mir_q   <= mir_n;
         gpc_q   <= gpc_n;
      end
   end

   assign int_hold_o = (state_q != PG_IDLE);
   assign pfx_dup_o  = dup;

   thor2022_bundle_reg #(.W(BW)) u_bundle (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .load_i  (load),
      .take_i  (out_ready_i),
      .d_i     (bdl_d),
      .valid_o (out_valid_o),
      .q_o     (bdl_q)
   );

   assign {out_ir_o, out_xir_o, out_xval_o, out_mir_o, out_mval_o, out_pc_o} = bdl_q;

endmodule

// File: tb/tb_thor2022_prefix_gather.sv
// Directed scenarios plus random traffic checked against a transaction-level model.
module tb_thor2022_prefix_gather;
   import thor2022_pkg::*;

   logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
   logic        in_valid_i = 1'b0, out_ready_i = 1'b0;
   logic        in_ready_o, out_valid_o, out_xval_o, out_mval_o, int_hold_o, pfx_dup_o;
   logic [63:0] in_ir_i = '0, out_ir_o, out_xir_o, out_mir_o;
   logic [31:0] in_pc_i = '0, out_pc_o;

   thor2022_prefix_gather dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_ir_i(in_ir_i), .in_pc_i(in_pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ir_o(out_ir_o),
      .out_xir_o(out_xir_o), .out_xval_o(out_xval_o), .out_mir_o(out_mir_o),
      .out_mval_o(out_mval_o), .out_pc_o(out_pc_o), .int_hold_o(int_hold_o),
      .pfx_dup_o(pfx_dup_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] ir, xir, mir;
      logic        xval, mval;
      logic [31:0] pc;
   } bundle_t;

   int n_vec = 0, n_err = 0, n_dup = 0, n_bdl = 0;

   // Reference model: pending prefix group plus queue of bundles awaiting the decoder.
   bit          m_hx, m_hm;
   logic [63:0] m_xw, m_mw;
   logic [31:0] m_gpc;
   bundle_t     exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] mkword(input logic [7:0] op);
      logic [63:0] w;
      w = {$urandom, $urandom};
      w[7:0] = op;
      return w;
   endfunction

   function automatic logic [7:0] base_op();
      logic [7:0] op;
      do op = 8'($urandom); while (op inside {8'h46, 8'h47, 8'h48, 8'h49, 8'h4A,
                                               8'h4B, 8'h4C, 8'h4D, 8'h50});
      return op;
   endfunction

   function automatic logic [7:0] exi_op();
      logic [7:0] ops [8] = '{8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D};
      return ops[$urandom_range(0, 7)];
   endfunction

   task automatic model_clear();
      m_hx = 0; m_hm = 0; m_xw = '0; m_mw = '0;
      exp_q.delete();
   endtask

   // Registered outputs, checked at the negedge.
   task automatic check_regs();
      chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
      chk("int_hold", 64'(int_hold_o), 64'(m_hx || m_hm));
      if (exp_q.size() != 0 && out_valid_o) begin
         chk("out_ir", out_ir_o, exp_q[0].ir);
         chk("out_xir", out_xir_o, exp_q[0].xir);
         chk("out_xval", 64'(out_xval_o), 64'(exp_q[0].xval));
         chk("out_mir", out_mir_o, exp_q[0].mir);
         chk("out_mval", 64'(out_mval_o), 64'(exp_q[0].mval));
         chk("out_pc", 64'(out_pc_o), 64'(exp_q[0].pc));
      end
   endtask

   // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
   task automatic step(input logic v, input logic [63:0] w, input logic [31:0] pc,
                       input logic fl, input logic ordy);
      bit rdy, acc, dup, is_x, is_m;
      bundle_t b;
      check_regs();
      in_valid_i = v; in_ir_i = w; in_pc_i = pc; flush_i = fl; out_ready_i = ordy;
      #1;
      rdy  = !fl && (exp_q.size() == 0 || ordy);
      acc  = v && rdy;
      dup  = 0;
      is_x = w[7:0] inside {8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D};
      is_m = (w[7:0] == 8'h50);
      chk("in_ready", 64'(in_ready_o), 64'(rdy));
      if (fl) begin
         model_clear();
      end else begin
         if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
         if (acc) begin
            if (is_x || is_m) begin
               if (!m_hx && !m_hm) m_gpc = pc;
               if (is_x) begin dup = m_hx; m_hx = 1; m_xw = w; end
               else      begin dup = m_hm; m_hm = 1; m_mw = w; end
            end else begin
               b.ir = w; b.xval = m_hx; b.mval = m_hm;
               b.xir = m_hx ? m_xw : 64'h0;
               b.mir = m_hm ? m_mw : 64'h0;
               b.pc  = (m_hx || m_hm) ? m_gpc : pc;
               exp_q.push_back(b);
               n_bdl++;
               m_hx = 0; m_hm = 0;
            end
         end
      end
      if (pfx_dup_o) n_dup++;
      chk("pfx_dup", 64'(pfx_dup_o), 64'(dup));
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [63:0] w1, w2;
      int d0;
      model_clear();
      repeat (2) @(negedge clk_i);
      // Reset values
      chk("rst_out_valid", 64'(out_valid_o), 64'h0);
      chk("rst_int_hold", 64'(int_hold_o), 64'h0);
      chk("rst_in_ready", 64'(in_ready_o), 64'h1);
      chk("rst_out_ir", out_ir_o, 64'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // 1: lone base word
      step(1'b1, mkword(8'h04), 32'h100, 1'b0, 1'b1);
      chk("t1_xval", 64'(out_xval_o), 64'h0);
      chk("t1_pc", 64'(out_pc_o), 64'h100);
      idle(1);

      // 2: EXI24 + EXIM + base
      w1 = mkword(EXI24); w2 = mkword(EXIM);
      step(1'b1, w1, 32'h200, 1'b0, 1'b1);
      step(1'b1, w2, 32'h208, 1'b0, 1'b1);
      step(1'b1, mkword(base_op()), 32'h210, 1'b0, 1'b1);
      chk("t2_pc", 64'(out_pc_o), 64'h200);
      chk("t2_xir", out_xir_o, w1);
      chk("t2_mir", out_mir_o, w2);
      idle(1);

      // 3: duplicate EXI8
      d0 = n_dup;
      w2 = mkword(EXI8 + 8'd1);
      step(1'b1, mkword(EXI8), 32'h300, 1'b0, 1'b1);
      step(1'b1, w2, 32'h308, 1'b0, 1'b1);
      step(1'b1, mkword(base_op()), 32'h310, 1'b0, 1'b1);
      chk("t3_xir", out_xir_o, w2);
      chk("t3_pc", 64'(out_pc_o), 64'h300);
      chk("t3_dup_count", 64'(n_dup - d0), 64'h1);
      idle(1);

      // 4: back-pressure for 3 cycles, then back-to-back issue
      step(1'b1, mkword(base_op()), 32'h400, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, mkword(base_op()), 32'h408, 1'b0, 1'b0);
      step(1'b1, mkword(base_op()), 32'h410, 1'b0, 1'b1);
      chk("t4_b2b_pc", 64'(out_pc_o), 64'h410);
      idle(1);

      // 5: flush kills partial group and the base word presented with it
      step(1'b1, mkword(EXI40), 32'h500, 1'b0, 1'b1);
      step(1'b1, mkword(base_op()), 32'h508, 1'b1, 1'b1);
      chk("t5_hold", 64'(int_hold_o), 64'h0);
      step(1'b1, mkword(base_op()), 32'h510, 1'b0, 1'b1);
      chk("t5_xval", 64'(out_xval_o), 64'h0);
      chk("t5_pc", 64'(out_pc_o), 64'h510);
      idle(1);

      // 6: asynchronous reset in GOT_XM
      step(1'b1, mkword(EXI56), 32'h600, 1'b0, 1'b1);
      step(1'b1, mkword(EXIM), 32'h608, 1'b0, 1'b1);
      check_regs();
      in_valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_hold", 64'(int_hold_o), 64'h0);
      chk("t6_valid", 64'(out_valid_o), 64'h0);
      chk("t6_dup", 64'(pfx_dup_o), 64'h0);
      model_clear();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(1'b1, mkword(base_op()), 32'h700, 1'b0, 1'b1);
      chk("t6_xval", 64'(out_xval_o), 64'h0);
      chk("t6_mval", 64'(out_mval_o), 64'h0);
      idle(1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         int k;
         logic [7:0] op;
         k = $urandom_range(0, 5);
         op = (k < 2) ? exi_op() : (k == 2) ? EXIM : base_op();
         step(($urandom % 4) != 0, mkword(op), $urandom & 32'hFFFF_FFF8,
              ($urandom % 20) == 0, ($urandom % 4) != 0);
      end
      idle(3);
      chk("bundles_seen", 64'(n_bdl > 50), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
